// File: rtl/sort4_ctrl.sv
// sort4_ctrl: sorts four 4-bit elements with a fixed 6-step compare-exchange
// sequence, sharing one 4-bit magnitude comparator across all steps.

// 4-bit unsigned magnitude comparator: greater, less, equal.
module comparator_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       g,
    output logic       l,
    output logic       e
);
    assign g = (a > b);
    assign l = (a < b);
    assign e = (a == b);
endmodule

module sort4_ctrl #(
    parameter bit ASCEND = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] din,
    output logic        busy,
    output logic        done,
    output logic [15:0] dout,
    output logic [2:0]  swap_count
);
    localparam int unsigned EW = 4;
    localparam int unsigned NE = 4;
    localparam int unsigned SW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [SW-1:0]  step;
    logic [EW-1:0]  elem [NE];
    logic [1:0]     idx;
    logic [1:0]     idx_nxt;
    logic [EW-1:0]  cmp_a;
    logic [EW-1:0]  cmp_b;
    logic           cmp_g;
    logic           cmp_l;
    logic           cmp_e;
    logic           do_swap;

    // Lower index of the pair handled by each step: (0,1),(1,2),(2,3),(0,1),(1,2),(0,1).
    always_comb begin
        idx = 2'd0;
        case (step)
            3'd0:    idx = 2'd0;
            3'd1:    idx = 2'd1;
            3'd2:    idx = 2'd2;
            3'd3:    idx = 2'd0;
            3'd4:    idx = 2'd1;
            default: idx = 2'd0;
        endcase
        idx_nxt = 2'(idx + 2'd1);
        cmp_a   = elem[idx];
        cmp_b   = elem[idx_nxt];
    end

    comparator_4bit u_cmp (
        .a (cmp_a),
        .b (cmp_b),
        .g (cmp_g),
        .l (cmp_l),
        .e (cmp_e)
    );

    // Swap when the pair is out of order; equal values never move.
    assign do_swap = (ASCEND ? cmp_g : cmp_l) & ~cmp_e;

    // Pack element registers onto dout, element i at bits [4i+3:4i].
    always_comb begin
        dout = '0;
        for (int i = 0; i < int'(NE); i++) begin
            dout[i*EW +: EW] = elem[i];
        end
    end

    // Control FSM with element, step and swap counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            step       <= '0;
            swap_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < int'(NE); i++) begin
                elem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < int'(NE); i++) begin
                            elem[i] <= din[i*EW +: EW];
                        end
                        swap_count <= '0;
                        step       <= '0;
                        busy       <= 1'b1;
                        state      <= CMP;
                    end
                end
                CMP: begin
                    if (do_swap) begin
                        elem[idx]     <= cmp_b;
                        elem[idx_nxt] <= cmp_a;
                        swap_count    <= SW'(swap_count + 3'd1);
                    end
                    if (step == 3'd5) begin
                        step  <= '0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        step <= SW'(step + 3'd1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    step  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sort4_ctrl.sv
// tb_sort4_ctrl: checks an ascending and a descending sort4_ctrl against a
// value-histogram / inversion-count reference model.
module tb_sort4_ctrl;
    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] din;
    logic        busy_a, done_a, busy_d, done_d;
    logic [15:0] dout_a, dout_d;
    logic [2:0]  swap_a, swap_d;

    int total = 0;
    int bad   = 0;

    sort4_ctrl #(.ASCEND(1'b1)) u_asc (
        .clk(clk), .rst(rst), .start(start), .din(din),
        .busy(busy_a), .done(done_a), .dout(dout_a), .swap_count(swap_a)
    );

    sort4_ctrl #(.ASCEND(1'b0)) u_dsc (
        .clk(clk), .rst(rst), .start(start), .din(din),
        .busy(busy_d), .done(done_d), .dout(dout_d), .swap_count(swap_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: count it, report any mismatch.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Reference: sorted result from a value histogram; swaps = strict inversions.
    function automatic void model(input logic [15:0] d, input bit asc,
                                  output logic [15:0] res, output int swaps);
        int e [4];
        int hist [16];
        int k;
        for (int v = 0; v < 16; v++) hist[v] = 0;
        for (int i = 0; i < 4; i++) begin
            e[i] = int'(d[i*4 +: 4]);
            hist[e[i]]++;
        end
        swaps = 0;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (asc ? (e[i] > e[j]) : (e[i] < e[j])) swaps++;
        res = '0;
        k = 0;
        for (int v = 0; v < 16; v++) begin
            for (int c = 0; c < hist[v]; c++) begin
                if (asc) res[k*4 +: 4] = 4'(v);
                else     res[(3-k)*4 +: 4] = 4'(v);
                k++;
            end
        end
    endfunction

    // One sort on both instances; optional start re-pulse with new din mid-sort.
    task automatic run_sort(input logic [15:0] d, input bit repulse, input string name);
        logic [15:0] exp_a, exp_d;
        int sw_a, sw_d;
        int cyc, done_at, n_done_a, n_done_d;
        model(d, 1'b1, exp_a, sw_a);
        model(d, 1'b0, exp_d, sw_d);
        start = 1'b1;
        din   = d;
        step_clk();
        start = 1'b0;
        din   = 16'($urandom);
        cyc = 0; done_at = 0; n_done_a = 0; n_done_d = 0;
        while (busy_a && cyc < 20) begin
            cyc++;
            if (done_a) begin n_done_a++; done_at = cyc; end
            if (done_d) n_done_d++;
            if (repulse && cyc == 2) begin
                start = 1'b1;
                din   = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
            step_clk();
        end
        start = 1'b0;
        chk({name, " busy_cycles"}, 32'(cyc), 32'd7);
        chk({name, " done_cycle"}, 32'(done_at), 32'd7);
        chk({name, " done_pulses_asc"}, 32'(n_done_a), 32'd1);
        chk({name, " done_pulses_dsc"}, 32'(n_done_d), 32'd1);
        chk({name, " busy_dsc_idle"}, 32'(busy_d), 32'd0);
        chk({name, " dout_asc"}, 32'(dout_a), 32'(exp_a));
        chk({name, " swaps_asc"}, 32'(swap_a), 32'(sw_a));
        chk({name, " dout_dsc"}, 32'(dout_d), 32'(exp_d));
        chk({name, " swaps_dsc"}, 32'(swap_d), 32'(sw_d));
    endtask

    initial begin
        int n_done;
        rst   = 1'b1;
        start = 1'b1;
        din   = 16'hABCD;
        step_clk();
        step_clk();
        chk("reset busy", 32'(busy_a), 32'd0);
        chk("reset done", 32'(done_a), 32'd0);
        chk("reset dout", 32'(dout_a), 32'h0);
        chk("reset swaps", 32'(swap_a), 32'd0);
        chk("reset dout_dsc", 32'(dout_d), 32'h0);
        start = 1'b0;
        rst   = 1'b0;
        step_clk();

        // Directed cases with hand-derived results.
        run_sort(16'h1234, 1'b0, "rev");
        chk("rev dout_literal", 32'(dout_a), 32'h4321);
        chk("rev swaps_literal", 32'(swap_a), 32'd6);
        run_sort(16'hFA50, 1'b0, "sorted");
        chk("sorted dout_literal", 32'(dout_a), 32'hFA50);
        chk("sorted swaps_literal", 32'(swap_a), 32'd0);
        run_sort(16'h7777, 1'b0, "equal");
        chk("equal swaps_dsc_literal", 32'(swap_d), 32'd0);
        run_sort(16'h0F19, 1'b0, "desc");
        chk("desc dout_literal", 32'(dout_d), 32'h019F);
        chk("desc swaps_literal", 32'(swap_d), 32'd2);
        run_sort(16'h1234, 1'b1, "repulse");
        chk("repulse dout_literal", 32'(dout_a), 32'h4321);

        // Results hold in IDLE while din wiggles and start stays low.
        for (int i = 0; i < 4; i++) begin
            din = 16'($urandom);
            step_clk();
        end
        chk("hold dout", 32'(dout_a), 32'h4321);
        chk("hold swaps", 32'(swap_a), 32'd6);
        chk("hold busy", 32'(busy_a), 32'd0);

        // Reset during the third CMP cycle aborts the sort.
        start = 1'b1;
        din   = 16'h1234;
        step_clk();
        start = 1'b0;
        step_clk();
        step_clk();
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        chk("abort busy", 32'(busy_a), 32'd0);
        chk("abort done", 32'(done_a), 32'd0);
        chk("abort dout", 32'(dout_a), 32'h0);
        chk("abort swaps", 32'(swap_a), 32'd0);
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (done_a || busy_a) n_done++;
            step_clk();
        end
        chk("abort no_activity", 32'(n_done), 32'd0);

        // Randomized sorts, including equal-value-heavy patterns.
        for (int t = 0; t < 40; t++) begin
            logic [15:0] r;
            r = 16'($urandom);
            if (t % 4 == 3) r = r & 16'h3333;
            run_sort(r, (t % 5 == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
